// File: rtl/coin_credit_unit.sv
// coin_credit_unit: credit front-end for the vending controller.
// Decodes coin-acceptor strobes into a running balance, deducts PRICE once per
// product_make assertion, and pays credit back one unit per cycle on refund.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_coin_pulse       one-cycle strobe from coin acceptor
//   i_coin_type[1:0]   0=1 unit, 1=5, 2=10, 3=invalid
//   i_product_make     vend request level
//   i_coin_out         refund request level
//   o_coin             coin accepted strobe
//   o_coin_val         current credit balance
//   o_reject           coin refused strobe
//   o_change_pulse     one unit paid out strobe
//   o_vend_err         vend with insufficient credit strobe
//   o_busy             refund in progress
module coin_credit_unit #(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned PRICE      = 3,
  parameter int unsigned MAX_CREDIT = 250
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_coin_pulse,
  input  logic [1:0]          i_coin_type,
  input  logic                i_product_make,
  input  logic                i_coin_out,
  output logic                o_coin,
  output logic [CREDIT_W-1:0] o_coin_val,
  output logic                o_reject,
  output logic                o_change_pulse,
  output logic                o_vend_err,
  output logic                o_busy
);

  typedef enum logic [1:0] {StAccum, StHold, StRefund} state_e;

  localparam logic [CREDIT_W:0]   MaxCreditW = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PriceW     = CREDIT_W'(PRICE);

  state_e              r_state, w_state_d;
  logic [CREDIT_W-1:0] r_val, w_val_d;
  logic                r_coin, w_coin_d;
  logic                r_reject, w_reject_d;
  logic                r_change, w_change_d;
  logic                r_vend_err, w_vend_err_d;
  logic                r_busy;

  logic [CREDIT_W:0]   w_coin_amt;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;

  always_comb begin
    w_coin_amt = '0;
    case (i_coin_type)
      2'd0:    w_coin_amt = (CREDIT_W+1)'(1);
      2'd1:    w_coin_amt = (CREDIT_W+1)'(5);
      2'd2:    w_coin_amt = (CREDIT_W+1)'(10);
      default: w_coin_amt = '0;
    endcase
  end

  // One extra bit so the overflow check never sees a wrapped sum.
  assign w_sum     = {1'b0, r_val} + w_coin_amt;
  assign w_coin_ok = (i_coin_type != 2'd3) && (w_sum <= MaxCreditW);

  always_comb begin
    w_state_d    = r_state;
    w_val_d      = r_val;
    w_coin_d     = 1'b0;
    w_reject_d   = 1'b0;
    w_change_d   = 1'b0;
    w_vend_err_d = 1'b0;

    // Coin handling is shared by ACCUM and HOLD; REFUND refuses all coins.
    if (r_state != StRefund && i_coin_pulse) begin
      if (w_coin_ok) begin
        w_val_d  = w_sum[CREDIT_W-1:0];
        w_coin_d = 1'b1;
      end else begin
        w_reject_d = 1'b1;
      end
    end

    case (r_state)
      StAccum: begin
        if (i_coin_out) begin
          w_state_d = StRefund;
        end else if (i_product_make) begin
          // Price check on the pre-coin balance; a same-cycle coin still credits.
          if (r_val >= PriceW) begin
            w_val_d = w_val_d - PriceW;
          end else begin
            w_vend_err_d = 1'b1;
          end
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (i_coin_out) begin
          w_state_d = StRefund;
        end else if (!i_product_make) begin
          w_state_d = StAccum;
        end
      end
      StRefund: begin
        w_reject_d = i_coin_pulse;
        if (r_val != '0) begin
          w_val_d    = r_val - 1'b1;
          w_change_d = 1'b1;
        end else if (!i_coin_out) begin
          w_state_d = StAccum;
        end
      end
      default: w_state_d = StAccum;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StAccum;
      r_val      <= '0;
      r_coin     <= 1'b0;
      r_reject   <= 1'b0;
      r_change   <= 1'b0;
      r_vend_err <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_val      <= w_val_d;
      r_coin     <= w_coin_d;
      r_reject   <= w_reject_d;
      r_change   <= w_change_d;
      r_vend_err <= w_vend_err_d;
      r_busy     <= (w_state_d == StRefund);
    end
  end

  assign o_coin         = r_coin;
  assign o_coin_val     = r_val;
  assign o_reject       = r_reject;
  assign o_change_pulse = r_change;
  assign o_vend_err     = r_vend_err;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Directed self-checking bench for coin_credit_unit.
module tb_coin_credit_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_pulse = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       product_make = 1'b0;
  logic       coin_out = 1'b0;
  logic       coin, reject, change_pulse, vend_err, busy;
  logic [7:0] coin_val;

  int n_checks = 0;
  int n_errors = 0;

  coin_credit_unit #(.CREDIT_W(8), .PRICE(3), .MAX_CREDIT(250)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_coin_pulse   (coin_pulse),
    .i_coin_type    (coin_type),
    .i_product_make (product_make),
    .i_coin_out     (coin_out),
    .o_coin         (coin),
    .o_coin_val     (coin_val),
    .o_reject       (reject),
    .o_change_pulse (change_pulse),
    .o_vend_err     (vend_err),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic coin_in(input logic [1:0] t);
    coin_pulse = 1'b1;
    coin_type  = t;
    tick();
    coin_pulse = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_val", coin_val, 0);
    check("rst_coin", coin, 0);
    check("rst_busy", busy, 0);
    check("rst_reject", reject, 0);

    // Coins 1, 5, 10 back to back.
    coin_pulse = 1'b1;
    coin_type = 2'd0; tick(); check("c1_coin", coin, 1); check("c1_val", coin_val, 1);
    coin_type = 2'd1; tick(); check("c5_coin", coin, 1); check("c5_val", coin_val, 6);
    coin_type = 2'd2; tick(); check("c10_coin", coin, 1); check("c10_val", coin_val, 16);
    check("c10_rej", reject, 0);
    coin_pulse = 1'b0;
    tick(); check("coin_drop", coin, 0);

    // Level vend deducts once.
    product_make = 1'b1;
    tick(); check("vend1_val", coin_val, 13); check("vend1_err", vend_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); check("vend_hold_val", coin_val, 13);
    end
    product_make = 1'b0;
    tick(); check("vend_rel_val", coin_val, 13);
    product_make = 1'b1; tick(); check("vend2_val", coin_val, 10);
    product_make = 1'b0; tick();
    product_make = 1'b1; tick(); check("vend3_val", coin_val, 7);
    product_make = 1'b0; tick();
    product_make = 1'b1; tick(); check("vend4_val", coin_val, 4);
    product_make = 1'b0; tick();

    // Refund of 4 units, coin rejected while refunding.
    coin_out = 1'b1;
    tick(); check("rf_entry_busy", busy, 1); check("rf_entry_chg", change_pulse, 0);
    check("rf_entry_val", coin_val, 4);
    coin_in(2'd0);
    check("rf1_chg", change_pulse, 1); check("rf1_val", coin_val, 3);
    check("rf1_rej", reject, 1); check("rf1_coin", coin, 0);
    tick(); check("rf2_chg", change_pulse, 1); check("rf2_val", coin_val, 2);
    tick(); check("rf3_chg", change_pulse, 1); check("rf3_val", coin_val, 1);
    tick(); check("rf4_chg", change_pulse, 1); check("rf4_val", coin_val, 0);
    tick(); check("rf_idle_chg", change_pulse, 0); check("rf_idle_busy", busy, 1);
    coin_out = 1'b0;
    tick(); check("rf_exit_busy", busy, 0); check("rf_exit_val", coin_val, 0);

    // Insufficient credit vend with same-cycle coin.
    coin_in(2'd0);
    coin_in(2'd0);
    check("pre_err_val", coin_val, 2);
    product_make = 1'b1;
    coin_in(2'd1);
    check("err_pulse", vend_err, 1); check("err_coin", coin, 1); check("err_val", coin_val, 7);
    tick(); check("err_once", vend_err, 0); check("err_hold_val", coin_val, 7);
    product_make = 1'b0; tick();

    // Passing vend with same-cycle coin: 7 + 10 - 3.
    product_make = 1'b1;
    coin_in(2'd2);
    check("vc_val", coin_val, 14); check("vc_coin", coin, 1); check("vc_err", vend_err, 0);
    product_make = 1'b0; tick();

    // Fill to 248 and probe the MAX_CREDIT boundary.
    for (int i = 0; i < 23; i++) coin_in(2'd2);
    for (int i = 0; i < 4; i++) coin_in(2'd0);
    check("fill_val", coin_val, 248);
    coin_in(2'd1); check("ovf_rej", reject, 1); check("ovf_coin", coin, 0);
    check("ovf_val", coin_val, 248);
    coin_in(2'd0); check("to249", coin_val, 249);
    coin_in(2'd0); check("to250", coin_val, 250); check("to250_coin", coin, 1);
    coin_in(2'd0); check("max_rej", reject, 1); check("max_val", coin_val, 250);
    coin_in(2'd3); check("inv_rej", reject, 1); check("inv_val", coin_val, 250);

    // Vend at exactly PRICE.
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_val", coin_val, 0);
    coin_in(2'd3); check("inv0_rej", reject, 1); check("inv0_val", coin_val, 0);
    coin_in(2'd0); coin_in(2'd0); coin_in(2'd0);
    product_make = 1'b1; tick();
    check("exact_val", coin_val, 0); check("exact_err", vend_err, 0);
    product_make = 1'b0; tick();

    // Reset in the middle of a refund.
    coin_in(2'd1); coin_in(2'd0); coin_in(2'd0);
    check("pre_rr_val", coin_val, 7);
    coin_out = 1'b1;
    tick(); check("rr_busy", busy, 1);
    tick(); check("rr_chg", change_pulse, 1); check("rr_val", coin_val, 6);
    reset = 1'b1;
    tick(); check("rr_rst_val", coin_val, 0); check("rr_rst_busy", busy, 0);
    check("rr_rst_chg", change_pulse, 0);
    reset = 1'b0; coin_out = 1'b0;
    tick(); check("rr_after_chg", change_pulse, 0); check("rr_after_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coin_credit_unit.md
# coin_credit_unit

Front-end credit stage sitting directly upstream of the vending controller FSM. Decodes coin-acceptor strobes into a running credit balance, raises a one-cycle `coin` strobe and a live `coin_val` count for the controller, deducts the product price when the controller asserts `product_make`, and pays out remaining credit one unit per cycle while the controller asserts `coin_out`. Handles invalid coins, overflow and refund sequencing so the controller only sees clean credit information.

## Interface
- `CREDIT_W`, 8: width of the credit register and `coin_val`.
- `PRICE`, 3: credit units deducted per vend; must be ≥1.
- `MAX_CREDIT`, 250: highest balance accepted; must be < 2^CREDIT_W.

- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `coin_pulse`  in  1  one-cycle strobe from the coin acceptor.
- `coin_type`  in  2  denomination, sampled with `coin_pulse`: 0=1 unit, 1=5, 2=10, 3=invalid.
- `product_make`  in  1  level from the controller: vend requested.
- `coin_out`  in  1  level from the controller: refund requested.
- `coin`  out  1  one-cycle strobe: coin accepted.
- `coin_val`  out  CREDIT_W  current credit balance.
- `reject`  out  1  one-cycle strobe: coin refused (returned mechanically).
- `change_pulse`  out  1  one-cycle strobe per credit unit paid out.
- `vend_err`  out  1  one-cycle strobe: vend requested with insufficient credit.
- `busy`  out  1  high while in REFUND.

## Operation
- All outputs registered. Reset: state=ACCUM, `coin_val`=0, `coin`=`reject`=`change_pulse`=`vend_err`=`busy`=0. Reset wins over every other input in the same cycle, including mid-refund; undelivered change is discarded.
- Coin acceptance (ACCUM or HOLD, `coin_pulse`=1): val = decoded denomination. Reject if `coin_type`=3 or `coin_val`+val > MAX_CREDIT (sum evaluated at CREDIT_W+1 bits, no wrap). Otherwise add val and pulse `coin`.
- States:
  - ACCUM: accept coins. If `coin_out`=1 → REFUND (refund has priority over vend). Else if `product_make`=1: when `coin_val` ≥ PRICE, subtract PRICE; otherwise pulse `vend_err`, no change; either way → HOLD.
  - HOLD: vend acknowledged, waiting for `product_make` to drop, so a level vend deducts exactly once. Coins accepted. `coin_out`=1 → REFUND; `product_make`=0 → ACCUM.
  - REFUND: `busy`=1. Every `coin_pulse` is rejected (`reject` pulse, no credit change). While `coin_val`≠0: decrement by 1, pulse `change_pulse`. When `coin_val`=0 and `coin_out`=0 → ACCUM; with `coin_out` still 1, stay in REFUND at 0.
- Simultaneous coin and vend in ACCUM: the price check uses the pre-coin balance; if it passes, next `coin_val` = `coin_val` + val − PRICE (overflow check uses `coin_val`+val). If it fails, the coin still gets credited and `vend_err` still pulses.
- `coin_val` never underflows or exceeds MAX_CREDIT.

## Timing
- `coin_pulse` at cycle N → `coin`/`reject` high in cycle N+1 only; `coin_val` updated in N+1.
- `product_make` rising at N → `coin_val` reduced (or `vend_err`) in N+1; no further deduction until `product_make` is low for at least one cycle.
- `coin_out` at N with balance B → `change_pulse` high in cycles N+2 … N+B+1 (entry cycle, then one unit per cycle); `coin_val` reaches 0 in N+B+1.
- `coin_out` low while balance is nonzero: refund continues to 0 (refund is never aborted except by reset).
- Back-to-back `coin_pulse` on consecutive cycles: each one is processed independently.

## Test plan
- Reset, then coins of type 0,1,2 on consecutive cycles → `coin` pulses ×3, `coin_val` 1→6→16; `reject`=0.
- `coin_val`=16, `product_make` held high 5 cycles → `coin_val`=13 after one cycle, stays 13; HOLD→ACCUM after release.
- `coin_val`=2, `product_make`=1 → `vend_err` one pulse, `coin_val`=2; coin type 1 in the same cycle → `coin_val`=7.
- `coin_val`=248, coin type 1 → `reject` pulse, `coin_val`=248; coin type 3 at any balance → `reject`.
- `coin_val`=4, `coin_out` held high → 4 `change_pulse`s on consecutive cycles, `busy`=1, coin during refund rejected; `coin_out` low → ACCUM, `busy`=0.
- `reset` asserted in the middle of a refund with `coin_val`=7 → next cycle `coin_val`=0, `busy`=0, no further `change_pulse`.
